// File: rtl/fifo_wr_ctrl_pkg.sv
// fifo_wr_ctrl_pkg: shared constants for the FIFO write-burst controller.
//   - 2-bit FSM state encoding (IDLE/SETTLE/WRITE/DONE)
//   - data-generator modes, seeds and the 8-bit Fibonacci LFSR tap mask
package fifo_wr_ctrl_pkg;

  localparam int unsigned ST_W        = 2;
  localparam int unsigned BURST_CNT_W = 16;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SETTLE = 2'd1;
  localparam logic [ST_W-1:0] ST_WRITE  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE   = 2'd3;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_LFSR  = 1'b1;

  localparam logic [7:0] SEED_COUNT = 8'h00;
  localparam logic [7:0] SEED_LFSR  = 8'h01;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

endpackage

// File: rtl/fifo_wr_pattern.sv
// fifo_wr_pattern: write-data generator (incrementing count or Fibonacci LFSR).
//   wr_clk  : clock
//   rst     : asynchronous active-high reset, clears data to 0
//   load    : load the seed selected by mode
//   advance : step the generator by one word
//   mode    : 0 = count, 1 = LFSR
//   data    : registered generator output
module fifo_wr_pattern
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              mode,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] TAPS     = DATA_W'(LFSR_TAPS);
  localparam logic [DATA_W-1:0] SEED_CNT = DATA_W'(SEED_COUNT);
  localparam logic [DATA_W-1:0] SEED_LFS = DATA_W'(SEED_LFSR);

  logic [DATA_W-1:0] seed_c;
  logic [DATA_W-1:0] next_c;

  // Seed and successor word for the current mode
  always_comb begin
    seed_c = (mode == MODE_LFSR) ? SEED_LFS : SEED_CNT;
    if (mode == MODE_LFSR) begin
      // shift left, XOR of tapped bits feeds bit 0
      next_c = {data[DATA_W-2:0], ^(data & TAPS)};
    end else begin
      next_c = data + DATA_W'(1);
    end
  end

  // Data register; load has priority over advance
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= seed_c;
    end else if (advance) begin
      data <= next_c;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: waits for the (asynchronous) FIFO empty flag, lets the FIFO
// settle, then writes a burst of generated data until almost_full.
//   wr_clk       : write-domain clock
//   rst          : asynchronous active-high reset
//   empty        : FIFO empty flag, read-clock domain (synchronized here)
//   almost_full  : ends the burst; one more write is allowed in its slack
//   full         : used only to flag overflow
//   wr_rst_busy  : FIFO write-side reset in progress, aborts any burst
//   pattern_sel  : 0 = count, 1 = LFSR, latched when a burst is armed
//   fifo_wr_en   : registered write enable
//   fifo_wr_data : registered write data
//   burst_cnt    : number of completed bursts (wraps)
//   overflow_err : sticky write-while-full flag
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETTLE_CYC = 10
) (
  input  logic                   wr_clk,
  input  logic                   rst,
  input  logic                   empty,
  input  logic                   almost_full,
  input  logic                   full,
  input  logic                   wr_rst_busy,
  input  logic                   pattern_sel,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  output logic [BURST_CNT_W-1:0] burst_cnt,
  output logic                   overflow_err
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  logic             empty_d0;
  logic             empty_d1;
  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] settle_cnt_nxt;
  logic             mode_q;
  logic             mode_nxt;
  logic             pat_load_c;
  logic             burst_done_c;

  // Two-flop synchronizer for the read-domain empty flag
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      empty_d0 <= 1'b0;
      empty_d1 <= 1'b0;
    end else begin
      empty_d0 <= empty;
      empty_d1 <= empty_d0;
    end
  end

  // State, settle counter and latched pattern mode
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      mode_q     <= MODE_COUNT;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      mode_q     <= mode_nxt;
    end
  end

  // Next-state logic; wr_rst_busy overrides everything, including almost_full
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    mode_nxt       = mode_q;
    pat_load_c     = 1'b0;
    burst_done_c   = 1'b0;
    if (wr_rst_busy) begin
      state_nxt      = ST_IDLE;
      settle_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (empty_d1) begin
            state_nxt      = ST_SETTLE;
            settle_cnt_nxt = '0;
            mode_nxt       = pattern_sel;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt      = ST_WRITE;
            settle_cnt_nxt = '0;
            pat_load_c     = 1'b1;
          end else begin
            settle_cnt_nxt = settle_cnt + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          // the write in this cycle still lands inside the almost_full slack
          if (almost_full) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          state_nxt    = ST_IDLE;
          burst_done_c = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en   <= 1'b0;
      burst_cnt    <= '0;
      overflow_err <= 1'b0;
    end else begin
      fifo_wr_en <= (state_nxt == ST_WRITE);
      if (burst_done_c) begin
        burst_cnt <= burst_cnt + BURST_CNT_W'(1);
      end
      if (fifo_wr_en && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Data generator: seeded on entry to WRITE, stepped on every write
  fifo_wr_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .wr_clk  (wr_clk),
    .rst     (rst),
    .load    (pat_load_c),
    .advance (fifo_wr_en),
    .mode    (mode_q),
    .data    (fifo_wr_data)
  );

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the burst controller.
module tb_fifo_wr_ctrl;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SETTLE_CYC = 10;

  logic              wr_clk = 1'b0;
  logic              rst;
  logic              empty;
  logic              almost_full;
  logic              full;
  logic              wr_rst_busy;
  logic              pattern_sel;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic [15:0]       burst_cnt;
  logic              overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit m_sync [2];
  bit m_settling;
  int m_settle_left;
  bit m_writing;
  bit m_done;
  bit m_en;
  bit m_mode;
  bit m_ovf;
  int m_data;
  int m_bursts;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_ctrl #(
    .DATA_W     (DATA_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .empty        (empty),
    .almost_full  (almost_full),
    .full         (full),
    .wr_rst_busy  (wr_rst_busy),
    .pattern_sel  (pattern_sel),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .burst_cnt    (burst_cnt),
    .overflow_err (overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pat_next(input int d, input bit mode);
    int fb;
    if (mode) begin
      fb = ((d >> 7) ^ (d >> 5) ^ (d >> 4) ^ (d >> 3)) & 1;
      return ((d << 1) | fb) & 255;
    end
    return (d + 1) & 255;
  endfunction

  task automatic model_reset();
    m_sync[0] = 0; m_sync[1] = 0;
    m_settling = 0; m_settle_left = 0;
    m_writing = 0; m_done = 0; m_en = 0;
    m_mode = 0; m_ovf = 0; m_data = 0; m_bursts = 0;
  endtask

  // One clock edge of the model, using the inputs held across that edge
  task automatic model_edge();
    bit synced_empty;
    synced_empty = m_sync[1];
    if (m_en) m_data = pat_next(m_data, m_mode);
    if (m_en && full) m_ovf = 1;
    if (wr_rst_busy) begin
      m_settling = 0; m_writing = 0; m_done = 0;
    end else if (m_done) begin
      m_bursts = (m_bursts + 1) & 16'hFFFF;
      m_done = 0;
    end else if (m_writing) begin
      if (almost_full) begin m_writing = 0; m_done = 1; end
    end else if (m_settling) begin
      if (m_settle_left == 0) begin
        m_settling = 0; m_writing = 1;
        m_data = m_mode ? 1 : 0;
      end else begin
        m_settle_left--;
      end
    end else if (synced_empty) begin
      m_settling = 1; m_settle_left = SETTLE_CYC - 1; m_mode = pattern_sel;
    end
    m_en = m_writing;
    m_sync[1] = m_sync[0];
    m_sync[0] = empty;
  endtask

  task automatic check_outputs();
    chk("wr_en",     fifo_wr_en,   m_en);
    chk("wr_data",   fifo_wr_data, m_data[7:0]);
    chk("burst_cnt", burst_cnt,    m_bursts[15:0]);
    chk("overflow",  overflow_err, m_ovf);
  endtask

  task automatic step();
    @(posedge wr_clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_en(input int max_cyc);
    int n;
    n = 0;
    while (!fifo_wr_en && n < max_cyc) begin step(); n++; end
    if (!fifo_wr_en) chk("wait_en_timeout", 32'd0, 32'd1);
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_en",  fifo_wr_en,   0);
    chk("rst_async_dat", fifo_wr_data, 0);
    chk("rst_async_cnt", burst_cnt,    0);
    chk("rst_async_ovf", overflow_err, 0);
    @(negedge wr_clk);
    rst = 1'b0;
  endtask

  logic [7:0] lfsr_exp [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

  initial begin
    int lat;
    int n_wr;
    int idx;
    rst = 1'b1; empty = 1'b0; almost_full = 1'b0; full = 1'b0;
    wr_rst_busy = 1'b0; pattern_sel = 1'b0;
    #1;
    model_reset();
    check_outputs();
    run(2);
    @(negedge wr_clk);
    rst = 1'b0;

    // count burst: 201 writes, latency 2 + SETTLE_CYC + 1
    empty = 1'b1;
    lat = 0;
    while (!fifo_wr_en && lat < 50) begin step(); lat++; end
    chk("en_latency", lat, 2 + SETTLE_CYC + 1);
    n_wr = 0;
    while (fifo_wr_en && n_wr < 400) begin
      chk("cnt_word", fifo_wr_data, n_wr & 255);
      n_wr++;
      if (n_wr == 201) begin almost_full = 1'b1; empty = 1'b0; end
      step();
    end
    almost_full = 1'b0;
    chk("cnt_burst_len", n_wr, 201);
    step();
    chk("burst_cnt_1", burst_cnt, 1);
    run(5);

    // LFSR burst: 5 writes, then almost_full -> 6 words
    pattern_sel = 1'b1; empty = 1'b1;
    wait_en(40);
    idx = 0;
    while (fifo_wr_en && idx < 6) begin
      chk("lfsr_word", fifo_wr_data, lfsr_exp[idx]);
      idx++;
      if (idx == 6) begin almost_full = 1'b1; empty = 1'b0; pattern_sel = 1'b0; end
      step();
    end
    almost_full = 1'b0;
    chk("lfsr_len", idx, 6);
    chk("lfsr_en_off", fifo_wr_en, 0);
    step();
    chk("burst_cnt_2", burst_cnt, 2);
    run(5);

    // wr_rst_busy abort mid-WRITE
    empty = 1'b1;
    wait_en(40);
    run(4);
    wr_rst_busy = 1'b1; empty = 1'b0;
    step();
    chk("abort_en", fifo_wr_en, 0);
    run(2);
    wr_rst_busy = 1'b0;
    chk("abort_cnt", burst_cnt, 2);
    run(4);
    chk("abort_idle_cnt", burst_cnt, 2);

    // restart at seed, then overflow while writing
    empty = 1'b1;
    wait_en(40);
    chk("restart_seed", fifo_wr_data, 0);
    step();
    full = 1'b1;
    step();
    full = 1'b0;
    chk("ovf_set", overflow_err, 1);
    run(3);
    almost_full = 1'b1; empty = 1'b0;
    step();
    almost_full = 1'b0;
    run(6);
    chk("ovf_sticky", overflow_err, 1);
    chk("burst_cnt_3", burst_cnt, 3);

    // reset pulse mid-WRITE
    empty = 1'b1;
    wait_en(40);
    run(3);
    empty = 1'b0;
    pulse_reset();
    run(5);
    chk("post_rst_ovf", overflow_err, 0);

    // one-cycle empty pulse while DONE
    empty = 1'b1;
    wait_en(40);
    run(2);
    almost_full = 1'b1; empty = 1'b0;
    step();
    almost_full = 1'b0; empty = 1'b1;
    step();
    empty = 1'b0;
    run(40);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) empty = ~empty;
      almost_full = ($urandom_range(0, 7) == 0);
      full        = ($urandom_range(0, 24) == 0);
      wr_rst_busy = ($urandom_range(0, 40) == 0);
      pattern_sel = 1'($urandom);
      if ($urandom_range(0, 599) == 0) pulse_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter: DATA_W, default 8, FIFO write data width.
REQ-002 Parameter: SETTLE_CYC, default 10, wr_clk cycles to wait after synchronized empty before a burst starts.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 wr_clk  input  1  write-domain clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 empty  input  1  FIFO empty flag, read-clock domain, asynchronous to wr_clk.
REQ-007 almost_full  input  1  FIFO almost-full flag, wr_clk domain.
REQ-008 full  input  1  FIFO full flag, wr_clk domain.
REQ-009 wr_rst_busy  input  1  FIFO write-side reset busy, wr_clk domain.
REQ-010 pattern_sel  input  1  0 = incrementing count, 1 = LFSR; sampled only on IDLE->SETTLE.
REQ-011 fifo_wr_en  output  1  registered FIFO write enable.
REQ-012 fifo_wr_data  output  DATA_W  registered FIFO write data.
REQ-013 burst_cnt  output  16  completed-burst count.
REQ-014 overflow_err  output  1  sticky write-while-full error.

Function
REQ-015 empty SHALL pass through a 2-flop synchronizer (empty_d0, empty_d1); only empty_d1 is used internally.
REQ-016 States SHALL be IDLE, SETTLE, WRITE, DONE.
REQ-017 IDLE->SETTLE when empty_d1=1 and wr_rst_busy=0; latch pattern_sel; load settle counter with 0.
REQ-018 SETTLE: counter increments each cycle; at count SETTLE_CYC-1, go to WRITE; data register loaded with seed (0x00 count mode, 0x01 LFSR mode).
REQ-019 WRITE: fifo_wr_en=1 every cycle; fifo_wr_data advances on each cycle fifo_wr_en=1 (count: +1 mod 2^DATA_W; LFSR: Fibonacci, taps x^8+x^6+x^5+x^4+1 for DATA_W=8, shift-left, feedback into bit 0).
REQ-020 First word of every burst SHALL equal the seed.
REQ-021 In WRITE, when almost_full=1 is sampled, next state DONE and fifo_wr_en=0 from the following cycle; exactly one write may occur in the sampling cycle (uses the almost_full slack).
REQ-022 DONE: burst_cnt increments by 1 (wraps 0xFFFF->0x0000); go to IDLE next cycle; a new burst needs empty_d1=1 again.
REQ-023 wr_rst_busy=1 in any state SHALL force IDLE next cycle, fifo_wr_en=0, burst_cnt unchanged (aborted burst not counted).
REQ-024 overflow_err SHALL set on any cycle with fifo_wr_en=1 and full=1, and remain set until rst.
REQ-025 almost_full and wr_rst_busy both 1 in the same cycle: wr_rst_busy wins (IDLE, no count).
REQ-026 fifo_wr_en SHALL be 0 in IDLE, SETTLE, DONE.

Reset
REQ-027 While rst=1 and asynchronously on its assertion: state=IDLE, fifo_wr_en=0, fifo_wr_data=0, burst_cnt=0, overflow_err=0, synchronizer flops=0, settle counter=0.
REQ-028 Reset mid-burst SHALL drop fifo_wr_en without waiting for a clock edge; after release, operation restarts from IDLE.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit, IDLE=0, SETTLE=1, WRITE=2, DONE=3), LFSR seed and tap mask constants.
REQ-030 The LFSR/counter data generator SHALL be one sub-module, fifo_wr_pattern (load, advance, mode, data out).

Verification
REQ-031 empty=1 held, pattern_sel=0, almost_full asserts after 200 writes -> fifo_wr_en rises 2+SETTLE_CYC+1 cycles after empty, data 0x00,0x01,...; 201 writes; burst_cnt=1.
REQ-032 pattern_sel=1, 5 writes then almost_full -> data 0x01,0x02,0x04,0x08,0x11,0x23; burst_cnt increments.
REQ-033 wr_rst_busy=1 for 3 cycles in WRITE -> fifo_wr_en=0 next cycle, burst_cnt unchanged, state IDLE; new burst restarts at seed.
REQ-034 Force full=1 with fifo_wr_en=1 one cycle -> overflow_err=1 and stays 1 after full=0 until rst.
REQ-035 rst pulse mid-WRITE -> fifo_wr_en=0 immediately, all outputs 0, burst_cnt=0.
REQ-036 empty pulse of 1 wr_clk cycle during DONE -> no second burst unless empty_d1=1 in IDLE.
